cp0_ctrl: RTL and testbench

Coprocessor-0 block in the M stage of the P7 pipeline. It consumes the M-stage exception record (`M_PC`, `M_isBD`, `EM_ExcCode`) and the external hardware interrupt lines, and raises `req`, the flush/redirect request that the pipeline registers act on. It also holds SR, Cause and EPC for `mfc0`/`mtc0`/`eret`.

---
 rtl/cp0_ctrl_pkg.sv | 38 +++
 rtl/cp0_req_gen.sv | 26 ++
 rtl/cp0_ctrl.sv | 126 ++++++++++++
 tb/tb_cp0_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/cp0_ctrl_pkg.sv
// Shared CP0 constants: register numbers, exception codes and SR/Cause field positions.
// Optional PRId register is enabled with the CP0_PRID_EN macro.
package cp0_ctrl_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  localparam int SR_IE   = 0;
  localparam int SR_EXL  = 1;
  localparam int IM_LO   = 10;
  localparam int IM_HI   = 15;
  localparam int IP_LO   = 10;
  localparam int IP_HI   = 15;
  localparam int EXC_LO  = 2;
  localparam int EXC_HI  = 6;
  localparam int CAU_BD  = 31;

  function automatic logic [31:0] epc_of(
    input logic [31:0] pc,
    input logic        bd
  );
    logic [31:0] r;
    r = bd ? pc - 32'd4 : pc;
    return {r[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_req_gen.sv
// Combinational interrupt/exception request logic for CP0.
// Interrupts take priority over the M-stage exception code.
module cp0_req_gen
  import cp0_ctrl_pkg::*;
(
  input  logic       reset,
  input  logic [5:0] hw_int,
  input  logic [5:0] im,
  input  logic       ie,
  input  logic       exl,
  input  logic [4:0] exc_code,
  output logic       req,
  output logic [4:0] exc_next
);

  logic int_req;
  logic exc_req;

  always_comb begin
    int_req  = (|(hw_int & im)) & ie & ~exl;
    exc_req  = (exc_code != EXC_INT) & ~exl;
    req      = (int_req | exc_req) & ~reset;
    exc_next = int_req ? EXC_INT : exc_code;
  end

endmodule

// File: rtl/cp0_ctrl.sv
// CP0 in the M stage: SR/Cause/EPC state, flush request, mfc0/mtc0/eret.
// Define CP0_PRID_EN to make register 15 read PRID_VAL.
module cp0_ctrl
  import cp0_ctrl_pkg::*;
#(
  parameter logic [31:0] PRID_VAL = 32'h2023_0007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        isBD,
  input  logic [4:0]  ExcCode,
  input  logic        EXLClr,
  input  logic [5:0]  HWInt,
  output logic        req,
  output logic [31:0] EPCOut,
  output logic [31:0] DOut
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;
  logic [4:0]  exc_next;
  logic [31:0] sr_rd;
  logic [31:0] cause_rd;
  logic [31:0] prid_rd;

  cp0_req_gen u_req_gen (
    .reset    (reset),
    .hw_int   (HWInt),
    .im       (im_q),
    .ie       (ie_q),
    .exl      (exl_q),
    .exc_code (ExcCode),
    .req      (req),
    .exc_next (exc_next)
  );

  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    exc_d = exc_q;
    epc_d = epc_q;
    ip_d  = HWInt;
    if (req) begin
      exl_d = 1'b1;
      exc_d = exc_next;
      bd_d  = isBD;
      epc_d = epc_of(PC, isBD);
    end else begin
      if (WE && A2 == REG_SR) begin
        im_d  = DIn[IM_HI:IM_LO];
        exl_d = DIn[SR_EXL];
        ie_d  = DIn[SR_IE];
      end
      if (WE && A2 == REG_EPC) begin
        epc_d = DIn;
      end
      // eret overrides an EXL value written in the same cycle
      if (EXLClr) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

`ifdef CP0_PRID_EN
  assign prid_rd = PRID_VAL;
`else
  assign prid_rd = PRID_VAL & 32'h0;
`endif

  always_comb begin
    sr_rd = '0;
    sr_rd[IM_HI:IM_LO] = im_q;
    sr_rd[SR_EXL] = exl_q;
    sr_rd[SR_IE] = ie_q;
    cause_rd = '0;
    cause_rd[CAU_BD] = bd_q;
    cause_rd[IP_HI:IP_LO] = ip_q;
    cause_rd[EXC_HI:EXC_LO] = exc_q;
  end

  always_comb begin
    DOut = '0;
    unique case (1'b1)
      (A1 == REG_SR):    DOut = sr_rd;
      (A1 == REG_CAUSE): DOut = cause_rd;
      (A1 == REG_EPC):   DOut = epc_q;
      (A1 == REG_PRID):  DOut = prid_rd;
      default:           DOut = '0;
    endcase
  end

  assign EPCOut = epc_q;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed vector bench for cp0_ctrl: one table row per clock cycle.
// Inputs are driven on the falling edge and outputs sampled 1ns later.
module tb_cp0_ctrl;

`ifdef CP0_PRID_EN
  localparam logic [31:0] EXP_PRID = 32'h2023_0007;
`else
  localparam logic [31:0] EXP_PRID = 32'h0;
`endif

  typedef struct {
    logic        rst;
    logic [4:0]  a1;
    logic        we;
    logic [4:0]  a2;
    logic [31:0] din;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
    logic        clr;
    logic [5:0]  hw;
    logic        e_req;
    logic        chk;
    logic [31:0] e_dout;
    logic [31:0] e_epc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  A1 = '0, A2 = '0, ExcCode = '0;
  logic [31:0] DIn = '0, PC = '0;
  logic        WE = 1'b0, isBD = 1'b0, EXLClr = 1'b0;
  logic [5:0]  HWInt = '0;
  logic        req;
  logic [31:0] EPCOut, DOut;

  int errors = 0;
  int checks = 0;
  vec_t tv[$];

  cp0_ctrl dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
    .PC(PC), .isBD(isBD), .ExcCode(ExcCode), .EXLClr(EXLClr),
    .HWInt(HWInt), .req(req), .EPCOut(EPCOut), .DOut(DOut)
  );

  always #5 clk = ~clk;

  task automatic add(
    input logic rst, input logic [4:0] a1, input logic we,
    input logic [4:0] a2, input logic [31:0] din, input logic [31:0] pc,
    input logic bd, input logic [4:0] exc, input logic clr,
    input logic [5:0] hw, input logic e_req, input logic chk,
    input logic [31:0] e_dout, input logic [31:0] e_epc
  );
    vec_t v;
    v.rst = rst; v.a1 = a1; v.we = we; v.a2 = a2; v.din = din;
    v.pc = pc; v.bd = bd; v.exc = exc; v.clr = clr; v.hw = hw;
    v.e_req = e_req; v.chk = chk; v.e_dout = e_dout; v.e_epc = e_epc;
    tv.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; A1 = v.a1; WE = v.we; A2 = v.a2; DIn = v.din;
    PC = v.pc; isBD = v.bd; ExcCode = v.exc; EXLClr = v.clr;
    HWInt = v.hw;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    vec_t v;
    // rst a1 we a2 din pc bd exc clr hw | req chk dout epc
    add(1, 12, 0, 0, 0, 0, 0, 12, 0, 0, 0, 0, 0, 0);
    add(0, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 12, 0, 0, 0, 32'h3008, 0, 12, 0, 0, 1, 1, 0, 0);
    add(0, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h30, 32'h3008);
    add(0, 12, 0, 0, 0, 0, 0, 4, 0, 0, 0, 1, 32'h2, 32'h3008);
    add(0, 12, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h2, 32'h3008);
    add(0, 12, 0, 0, 0, 32'h300C, 1, 4, 0, 0, 1, 1, 0, 32'h3008);
    add(0, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0010, 32'h3008);
    add(0, 14, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h3008, 32'h3008);
    add(0, 12, 1, 12, 32'h401, 0, 0, 0, 0, 0, 0, 1, 0, 32'h3008);
    add(0, 12, 0, 0, 0, 32'h4000, 0, 0, 0, 1, 1, 1, 32'h401, 32'h3008);
    add(0, 13, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h400, 32'h4000);
    add(0, 12, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h403, 32'h4000);
    add(0, 13, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h400, 32'h4000);
    add(0, 12, 0, 0, 0, 32'h5004, 0, 8, 0, 1, 1, 1, 32'h401, 32'h4000);
    add(0, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h400, 32'h5004);
    add(0, 12, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h403, 32'h5004);
    add(0, 14, 1, 14, 32'h1234, 32'h6008, 0, 10, 0, 0, 1, 1,
        32'h5004, 32'h5004);
    add(0, 14, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h6008, 32'h6008);
    add(0, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h401, 32'h6008);
    add(0, 13, 1, 12, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 0, 1,
        32'h28, 32'h6008);
    add(0, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFC01, 32'h6008);
    add(0, 13, 1, 13, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 1,
        32'h28, 32'h6008);
    add(0, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h28, 32'h6008);
    add(0, 15, 1, 14, 32'h1235, 0, 0, 0, 0, 0, 0, 1, EXP_PRID, 32'h6008);
    add(0, 14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1235, 32'h1235);
    add(0, 12, 0, 0, 0, 32'h2, 1, 5, 0, 0, 1, 1, 32'hFC01, 32'h1235);
    add(0, 14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    add(1, 12, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'hFC03, 32'hFFFF_FFFC);
    add(0, 12, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    add(0, 13, 1, 3, 32'hDEAD, 0, 0, 0, 0, 0, 0, 1, 32'h400, 0);
    add(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      check($sformatf("row%0d req", i), {31'b0, req}, {31'b0, tv[i].e_req});
      if (tv[i].chk) begin
        check($sformatf("row%0d dout", i), DOut, tv[i].e_dout);
        check($sformatf("row%0d epc", i), EPCOut, tv[i].e_epc);
      end
    end

    // IE/IM gating: a line outside IM is ignored until IM is widened
    v = tv[0];
    v.rst = 0; v.exc = 0; v.a1 = 12; v.hw = 6'b000010;
    v.we = 1; v.a2 = 12; v.din = 32'h401;
    @(negedge clk); drive(v); #1;
    check("gate_ie0 req", {31'b0, req}, 32'h0);
    v.we = 0;
    @(negedge clk); drive(v); #1;
    check("gate_im req", {31'b0, req}, 32'h0);
    check("gate_im sr", DOut, 32'h401);
    v.we = 1; v.din = 32'h801;
    @(negedge clk); drive(v); #1;
    check("gate_im2 req", {31'b0, req}, 32'h0);
    v.we = 0;
    @(negedge clk); drive(v); #1;
    check("gate_open req", {31'b0, req}, 32'h1);
    v.hw = 0; v.a1 = 13;
    @(negedge clk); drive(v); #1;
    check("gate_open cause", DOut, 32'h800);
    check("gate_open epc", EPCOut, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
